// File: rtl/fc_mac_array.sv
// Pipelined FC-layer MAC array: per-lane products, lane reduction, neuron accumulate,
// bias add and saturation. Define FC_MAC_RELU_EN to zero negative results after saturation.
module fc_mac_lane #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 4
) (
  input  logic                       clk,
  input  logic [DATA_W-1:0]          data,
  input  logic [WEIGHT_W-1:0]        weight,
  output logic [DATA_W+WEIGHT_W-1:0] prod
);
  always_ff @(posedge clk) prod <= $signed(data) * $signed(weight);
endmodule

module fc_mac_array #(
  parameter int NUM_LANES = 20,
  parameter int DATA_W    = 8,
  parameter int WEIGHT_W  = 4,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 16,
  parameter int BIAS_W    = 16
) (
  input  logic                          clk,
  input  logic                          srstn,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data,
  input  logic [NUM_LANES*WEIGHT_W-1:0] in_weight,
  input  logic [BIAS_W-1:0]             in_bias,
  output logic                          out_valid,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_sat
);
  localparam int PW     = DATA_W + WEIGHT_W;
  localparam int STAGES = 2;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic              last;
    logic [BIAS_W-1:0] bias;
  } ctl_t;

  logic [STAGES:1]              vld_pipe;
  ctl_t                         ctl1, ctl2;
  logic [NUM_LANES-1:0][PW-1:0] prod1;
  logic signed [ACC_W-1:0]      sum_c, sum2, acc, acc_next, res_c, res3;
  logic                         first, v3;
  logic [OUT_W-1:0]             clip;
  logic                         clip_sat;

  // S1: lane i sits at the MSB end of the flat buses
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fc_mac_lane #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) u_lane (
      .clk    (clk),
      .data   (in_data[DATA_W*(NUM_LANES-1-i) +: DATA_W]),
      .weight (in_weight[WEIGHT_W*(NUM_LANES-1-i) +: WEIGHT_W]),
      .prod   (prod1[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!srstn) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    ctl1 <= '{last: in_last, bias: in_bias};
    ctl2 <= ctl1;
    sum2 <= sum_c;
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_LANES; i++) sum_c = sum_c + ACC_W'($signed(prod1[i]));
  end

  // S3: accumulate; bias add uses acc_next so a single-beat neuron needs no extra cycle
  always_comb begin
    acc_next = first ? sum2 : acc + sum2;
    res_c    = acc_next + ACC_W'($signed(ctl2.bias));
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      acc   <= '0;
      first <= 1'b1;
      v3    <= 1'b0;
    end else begin
      v3 <= vld_pipe[STAGES] & ctl2.last;
      if (vld_pipe[STAGES]) begin
        acc   <= acc_next;
        first <= ctl2.last;
      end
    end
    res3 <= res_c;
  end

  // S4: saturate, then optional ReLU which does not flag saturation
  always_comb begin
    clip_sat = 1'b0;
    clip     = res3[OUT_W-1:0];
    if (res3 > SAT_MAX) begin
      clip     = SAT_MAX[OUT_W-1:0];
      clip_sat = 1'b1;
    end else if (res3 < SAT_MIN) begin
      clip     = SAT_MIN[OUT_W-1:0];
      clip_sat = 1'b1;
    end
`ifdef FC_MAC_RELU_EN
    if (clip[OUT_W-1]) clip = '0;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= v3;
      if (v3) begin
        out_data <= clip;
        out_sat  <= clip_sat;
      end
    end
  end
endmodule
